full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
Registered full adder with parameterised operand width. It sums operands a and b plus carry-in c and registers the sum and carry-out.
- Built as a ripple chain of one-bit full-adder cells.
- Used as a leaf arithmetic cell in datapaths.
- The default WIDTH=1 gives the classic 1-bit full adder: sum = a^b^c, cout = majority(a,b,c).

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
c  input  1  carry-in
sum  output  WIDTH  registered sum bits
cout  output  1  registered carry-out
out_valid  output  1  sum/cout updated last cycle

Interface notes:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Port order after clk, rst_n, in_valid: sum, cout, a, b, c.

Behaviour:
- Reset:
  - rst_n low forces sum=0, cout=0, out_valid=0 immediately, independent of clk.
  - Release is sampled at the next rising edge.
- Arithmetic:
  - {cout,sum} = a + b + c, computed at WIDTH+1 bits.
  - No truncation beyond WIDTH+1 bits; carry-out is the only overflow indication.
- Ripple chain:
  - Bit i: s_i = a_i^b_i^k_i; k_{i+1} = a_i&b_i | a_i&k_i | b_i&k_i.
  - k_0 = c; cout = k_WIDTH.
- Latency:
  - Exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on sum/cout after edge N, with out_valid=1 for that one cycle.
- Hold:
  - in_valid=0 at an edge: sum/cout keep their previous values; out_valid=0.
- Back-to-back:
  - in_valid high every cycle gives one result per cycle; no stalls, no backpressure.
- Reset mid-operation:
  - An in-flight result is discarded; outputs read 0 until the next accepted input.
- Wrap-around:
  - a=b=all-ones with c=1 gives sum=all-ones, cout=1.
  - a=all-ones, b=0, c=1 gives sum=0, cout=1.
- X-safety: the sum/cout registers update only when in_valid is 1, so X on a/b/c while in_valid=0 is never captured.

Optional Feature:
FULL_ADDER_OVF_EN:
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum.
  - ovf = k_WIDTH ^ k_{WIDTH-1}, i.e. two's-complement signed overflow of a+b+c.
  - Reset value 0; holds when in_valid=0.
  - For WIDTH=1, ovf = cout ^ c.
- Not defined: no ovf port; the rest of the behaviour is identical.

Decomposition:
- Package full_adder_pkg:
  - localparam FA_DEFAULT_WIDTH = 1.
  - localparam FA_MAX_WIDTH = 64.
  - Function fa_ref(a,b,c) returning the WIDTH+1-bit reference sum, for the bench.
- Sub-module fa_bit: purely combinational one-bit full adder.
  - Ports: s, co, x, y, ci.
  - Instantiated WIDTH times via generate.
- Top level: generate chain, output registers, valid flop, optional ovf register.

Test Plan:
1. WIDTH=1 exhaustive: {a,b,c}=0..7 with in_valid=1, one per cycle → sum/cout one cycle later = 00,10,10,01,10,01,01,11 (sum,cout); out_valid=1 each cycle.
2. WIDTH=8 wrap: a=8'hFF, b=8'h01, c=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, c=1 → sum=8'hFF, cout=1.
3. Hold: accept a=3, b=4, c=1 (WIDTH=4), then in_valid=0 for 3 cycles with random a/b → sum=4'h8, cout=0 held; out_valid=1 only in the first cycle.
4. Async reset mid-stream: assert rst_n=0 between edges while sum=4'h8 → sum, cout, out_valid go 0 immediately. After release, the next in_valid=1 with a=1, b=1, c=0 gives sum=2.
5. FULL_ADDER_OVF_EN, WIDTH=8: a=8'h7F, b=8'h00, c=1 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80, c=0 → sum=0, cout=1, ovf=1.
6. Random WIDTH=16: 10k random a/b/c with random in_valid → {cout,sum} matches fa_ref at 1-cycle latency; out_valid equals in_valid delayed one cycle.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and reference arithmetic for the full_adder slice.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;

  // Zero-extended a+b+c at FA_MAX_WIDTH+1 bits.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    c
  );
    logic [FA_MAX_WIDTH:0] ci;
    ci = '0;
    ci[0] = c;
    return {1'b0, a} + {1'b0, b} + ci;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell.
module fa_bit (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,sum} = a + b + c, 1-cycle latency.
// FULL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  assign k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit u_bit (
      .s  (s[i]),
      .co (k[i+1]),
      .x  (a[i]),
      .y  (b[i]),
      .ci (k[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= k[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Carry into vs. out of the sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= k[WIDTH] ^ k[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at widths 1, 4, 8 and 16.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n = 0;
  int err = 0;

  always #5 clk = ~clk;

  logic       v1 = 0, c1 = 0, s1, co1, ov1;
  logic       a1 = 0, b1 = 0;
  logic       v4 = 0, c4 = 0, co4, ov4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic       v8 = 0, c8 = 0, co8, ov8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic        v16 = 0, c16 = 0, co16, ov16;
  logic [15:0] a16 = 0, b16 = 0, s16;
`ifdef FULL_ADDER_OVF_EN
  logic f1, f4, f8, f16;
`endif

  full_adder #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .sum(s1), .cout(co1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f1)
`endif
  );
  full_adder #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .sum(s4), .cout(co4), .a(a4), .b(b4), .c(c4),
    .out_valid(ov4)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f4)
`endif
  );
  full_adder #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .sum(s8), .cout(co8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f8)
`endif
  );
  full_adder #(.WIDTH(16)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16),
    .sum(s16), .cout(co16), .a(a16), .b(b16), .c(c16),
    .out_valid(ov16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f16)
`endif
  );

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow from the two's-complement value range.
  function automatic bit sovf(int w, longint ua,
                              longint ub, bit ci);
    longint hi, sa, sb, t;
    hi = longint'(1) << (w - 1);
    sa = (ua >= hi) ? ua - 2 * hi : ua;
    sb = (ub >= hi) ? ub - 2 * hi : ub;
    t = sa + sb + longint'(ci);
    return (t > hi - 1) || (t < -hi);
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n++;
    if ({ov1, co1, s1} !== 3'b0) begin
      err++;
      $display("FAIL reset_w1 got %b want 000", {ov1, co1, s1});
    end
    n++;
    if ({ov4, co4, s4} !== 6'b0) begin
      err++;
      $display("FAIL reset_w4 got %b want 0", {ov4, co4, s4});
    end
    n++;
    if ({ov8, co8, s8} !== 10'b0) begin
      err++;
      $display("FAIL reset_w8 got %b want 0", {ov8, co8, s8});
    end
    n++;
    if ({ov16, co16, s16} !== 18'b0) begin
      err++;
      $display("FAIL reset_w16 got %b want 0", {ov16, co16, s16});
    end
`ifdef FULL_ADDER_OVF_EN
    n++;
    if ({f1, f4, f8, f16} !== 4'b0) begin
      err++;
      $display("FAIL reset_ovf got %b want 0", {f1, f4, f8, f16});
    end
`endif
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_exhaustive_w1();
    int t;
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1;
      a1 = i[2];
      b1 = i[1];
      c1 = i[0];
      t = i[2] + i[1] + i[0];
      step();
      n++;
      if ({ov1, co1, s1} !== {1'b1, t[1], t[0]}) begin
        err++;
        $display("FAIL exh_w1 i=%0d got v/co/s=%b want %b",
                 i, {ov1, co1, s1}, {1'b1, t[1], t[0]});
      end
`ifdef FULL_ADDER_OVF_EN
      n++;
      if (f1 !== sovf(1, i[2], i[1], i[0])) begin
        err++;
        $display("FAIL ovf_w1 i=%0d got %b", i, f1);
      end
`endif
    end
    v1 = 1'b0;
  endtask

  task automatic apply8(logic [7:0] a, logic [7:0] b,
                        logic c, logic [7:0] es,
                        logic ec, string nm);
    v8 = 1'b1;
    a8 = a;
    b8 = b;
    c8 = c;
    step();
    n++;
    if ({ov8, co8, s8} !== {1'b1, ec, es}) begin
      err++;
      $display("FAIL %s got v/co/s=%b/%b/%h want 1/%b/%h",
               nm, ov8, co8, s8, ec, es);
    end
    v8 = 1'b0;
  endtask

  task automatic test_wrap_w8();
    apply8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap_ff_01");
    apply8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "wrap_ff_ff_c");
    apply8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "wrap_ff_00_c");
`ifdef FULL_ADDER_OVF_EN
    apply8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "ovf_7f");
    n++;
    if (f8 !== 1'b1) begin
      err++;
      $display("FAIL ovf_7f got %b want 1", f8);
    end
    apply8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf_80");
    n++;
    if (f8 !== 1'b1) begin
      err++;
      $display("FAIL ovf_80 got %b want 1", f8);
    end
    apply8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "ovf_none");
    n++;
    if (f8 !== 1'b0) begin
      err++;
      $display("FAIL ovf_none got %b want 0", f8);
    end
`endif
  endtask

  task automatic test_hold_w4();
    v4 = 1'b1;
    a4 = 4'd3;
    b4 = 4'd4;
    c4 = 1'b1;
    step();
    n++;
    if ({ov4, co4, s4} !== 6'b1_0_1000) begin
      err++;
      $display("FAIL hold_accept got %b want 101000",
               {ov4, co4, s4});
    end
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a4 = 'x;
        b4 = 'x;
        c4 = 'x;
      end else begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        c4 = 1'($urandom);
      end
      step();
      n++;
      if ({ov4, co4, s4} !== 6'b0_0_1000) begin
        err++;
        $display("FAIL hold_%0d got %b want 001000",
                 i, {ov4, co4, s4});
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n++;
    if ({ov4, co4, s4} !== 6'b0) begin
      err++;
      $display("FAIL async_rst got %b want 0", {ov4, co4, s4});
    end
    #1 rst_n = 1'b1;
    step();
    n++;
    if ({ov4, co4, s4} !== 6'b0) begin
      err++;
      $display("FAIL post_rst got %b want 0", {ov4, co4, s4});
    end
    v4 = 1'b1;
    a4 = 4'd1;
    b4 = 4'd1;
    c4 = 1'b0;
    step();
    n++;
    if ({ov4, co4, s4} !== 6'b1_0_0010) begin
      err++;
      $display("FAIL rst_resume got %b want 100010",
               {ov4, co4, s4});
    end
    v4 = 1'b0;
  endtask

  task automatic test_random_w16();
    logic [FA_MAX_WIDTH:0] r;
    logic [15:0] es = '0;
    logic ec = 1'b0;
`ifdef FULL_ADDER_OVF_EN
    logic eo = 1'b0;
`endif
    for (int i = 0; i < 10000; i++) begin
      v16 = 1'($urandom_range(0, 1));
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom_range(0, 1));
      if (v16) begin
        r = fa_ref(64'(a16), 64'(b16), c16);
        es = r[15:0];
        ec = r[16];
`ifdef FULL_ADDER_OVF_EN
        eo = sovf(16, longint'(a16), longint'(b16), c16);
`endif
      end
      step();
      n++;
      if ({ov16, co16, s16} !== {v16, ec, es}) begin
        err++;
        $display("FAIL rand_%0d got v/co/s=%b/%b/%h want %b/%b/%h",
                 i, ov16, co16, s16, v16, ec, es);
      end
`ifdef FULL_ADDER_OVF_EN
      n++;
      if (f16 !== eo) begin
        err++;
        $display("FAIL rand_ovf_%0d got %b want %b", i, f16, eo);
      end
`endif
    end
    v16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_wrap_w8();
    test_hold_w4();
    test_async_reset();
    test_random_w16();
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end

endmodule
